// File: rtl/tlp_tx_scheduler.sv
// Transmit TLP scheduler: arbitrates AW/AR header FIFOs onto one 256-bit stream and
// follows each write header with its payload beats. Define TLP_TX_WR_PRIORITY_EN for fixed write priority.
module tlp_tx_scheduler #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         aw_hdr_empty,
  input  logic [127:0] aw_hdr_rdata,
  output logic         aw_hdr_rden,
  input  logic         ar_hdr_empty,
  input  logic [127:0] ar_hdr_rdata,
  output logic         ar_hdr_rden,
  input  logic         wd_empty,
  input  logic [255:0] wd_rdata,
  output logic         wd_rden,
  output logic         tlp_valid,
  input  logic         tlp_ready,
  output logic [255:0] tlp_data,
  output logic         tlp_sop,
  output logic         tlp_eop,
  output logic         busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DATA = 1'b1;

  logic [0:0]  state;
  logic [7:0]  cnt;
  logic        out_free, wr_elig, rd_elig, grant_wr, grant_rd, idle_grant;
  logic [10:0] len_dw, beats;
  logic        unused_bits;

  assign out_free = !tlp_valid || tlp_ready;
  assign wr_elig  = !aw_hdr_empty && !wd_empty;
  assign rd_elig  = !ar_hdr_empty;

  // Length field of 0 encodes 1024 DW, so at most 128 beats: cnt fits in 8 bits.
  assign len_dw      = (aw_hdr_rdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, aw_hdr_rdata[9:0]};
  assign beats       = (len_dw + 11'd7) >> 3;
  assign unused_bits = ^{beats[10:8], (ADDR_WIDTH > 0)};

`ifdef TLP_TX_WR_PRIORITY_EN
  assign grant_wr = wr_elig;
`else
  logic last_grant;  // 1: most recent grant was a write
  assign grant_wr = wr_elig && (!rd_elig || !last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_grant <= 1'b0;
    else if (aw_hdr_rden) last_grant <= 1'b1;
    else if (ar_hdr_rden) last_grant <= 1'b0;
  end
`endif

  assign grant_rd    = rd_elig && !grant_wr;
  assign idle_grant  = !rst && (state == IDLE) && out_free;
  assign aw_hdr_rden = idle_grant && grant_wr;
  assign ar_hdr_rden = idle_grant && grant_rd;
  assign wd_rden     = !rst && (state == DATA) && out_free && !wd_empty;
  assign busy        = (state == DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      tlp_valid <= 1'b0;
      tlp_data  <= '0;
      tlp_sop   <= 1'b0;
      tlp_eop   <= 1'b0;
    end else if (out_free) begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            tlp_valid <= 1'b1;
            tlp_data  <= {128'b0, aw_hdr_rdata};
            tlp_sop   <= 1'b1;
            tlp_eop   <= 1'b0;
            cnt       <= beats[7:0];
            state     <= DATA;
          end else if (grant_rd) begin
            tlp_valid <= 1'b1;
            tlp_data  <= {128'b0, ar_hdr_rdata};
            tlp_sop   <= 1'b1;
            tlp_eop   <= 1'b1;
          end else begin
            tlp_valid <= 1'b0;
          end
        end
        default: begin
          // A dry write-data FIFO leaves a bubble but keeps the packet open.
          if (!wd_empty) begin
            tlp_valid <= 1'b1;
            tlp_data  <= wd_rdata;
            tlp_sop   <= 1'b0;
            tlp_eop   <= (cnt == 8'd1);
            cnt       <= cnt - 8'd1;
            if (cnt == 8'd1) state <= IDLE;
          end else begin
            tlp_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_tx_scheduler.sv
// Bench for tlp_tx_scheduler: queue-based FWFT FIFOs, a packet-level scoreboard and
// directed plus randomized traffic.
module tb_tlp_tx_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         aw_hdr_empty = 1'b1, ar_hdr_empty = 1'b1, wd_empty = 1'b1, tlp_ready = 1'b1;
  logic [127:0] aw_hdr_rdata = '0, ar_hdr_rdata = '0;
  logic [255:0] wd_rdata = '0;
  logic         aw_hdr_rden, ar_hdr_rden, wd_rden, tlp_valid, tlp_sop, tlp_eop, busy;
  logic [255:0] tlp_data;

  tlp_tx_scheduler dut (
    .clk(clk), .rst(rst),
    .aw_hdr_empty(aw_hdr_empty), .aw_hdr_rdata(aw_hdr_rdata), .aw_hdr_rden(aw_hdr_rden),
    .ar_hdr_empty(ar_hdr_empty), .ar_hdr_rdata(ar_hdr_rdata), .ar_hdr_rden(ar_hdr_rden),
    .wd_empty(wd_empty), .wd_rdata(wd_rdata), .wd_rden(wd_rden),
    .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
    .tlp_sop(tlp_sop), .tlp_eop(tlp_eop), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [127:0] aw_q[$], ar_q[$], exp_rd[$], exp_wr[$];
  logic [255:0] wd_q[$], exp_wd[$];
  bit           order_log[$];
  int           wr_left = 0, acc_in_pkt = 0, last_pkt_len = 0, wd_hide = 0;
  logic         prev_v = 1'b0, prev_r = 1'b0, prev_s = 1'b0, prev_e = 1'b0;
  logic [255:0] prev_d = '0;
  logic         pend_pop = 1'b0;
  logic [255:0] pend_val = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input logic [127:0] h);
    int len;
    len = int'(h[9:0]);
    if (len == 0) len = 1024;
    return (len + 7) / 8;
  endfunction

  function automatic int outstanding();
    return exp_rd.size() + exp_wr.size() + exp_wd.size() + wr_left + int'(tlp_valid);
  endfunction

  task automatic push_rd(input int len);
    logic [127:0] h;
    for (int k = 0; k < 4; k++) h[k*32 +: 32] = $urandom;
    h[9:0] = len[9:0];
    ar_q.push_back(h);
    exp_rd.push_back(h);
  endtask

  task automatic push_wr(input int len);
    logic [127:0] h;
    logic [255:0] d;
    for (int k = 0; k < 4; k++) h[k*32 +: 32] = $urandom;
    h[9:0] = len[9:0];
    aw_q.push_back(h);
    exp_wr.push_back(h);
    for (int b = 0; b < beats_of(h); b++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      wd_q.push_back(d);
      exp_wd.push_back(d);
    end
  endtask

  task automatic drive();
    aw_hdr_empty = (aw_q.size() == 0);
    aw_hdr_rdata = aw_hdr_empty ? '0 : aw_q[0];
    ar_hdr_empty = (ar_q.size() == 0);
    ar_hdr_rdata = ar_hdr_empty ? '0 : ar_q[0];
    wd_empty     = (wd_q.size() == 0) || (wd_hide > 0);
    wd_rdata     = (wd_q.size() == 0) ? '0 : wd_q[0];
  endtask

  task automatic accept();
    logic [255:0] e;
    if (tlp_sop) begin
      chk("sop_outside_pkt", wr_left, 0);
      chk("hdr_upper_zero", tlp_data[255:128], 0);
      acc_in_pkt = 1;
      if (tlp_eop) begin
        order_log.push_back(1'b0);
        e = (exp_rd.size() != 0) ? {128'b0, exp_rd.pop_front()} : {256{1'bx}};
        chk("rd_hdr", tlp_data, e);
      end else begin
        order_log.push_back(1'b1);
        e = (exp_wr.size() != 0) ? {128'b0, exp_wr.pop_front()} : {256{1'bx}};
        chk("wr_hdr", tlp_data, e);
        wr_left = (e[0] !== 1'bx) ? beats_of(e[127:0]) : 0;
      end
    end else begin
      acc_in_pkt++;
      chk("data_in_pkt", (wr_left != 0), 1);
      e = (exp_wd.size() != 0) ? exp_wd.pop_front() : {256{1'bx}};
      chk("wr_data", tlp_data, e);
      chk("wr_eop", tlp_eop, (wr_left == 1));
      if (wr_left > 0) wr_left--;
    end
    if (tlp_eop) last_pkt_len = acc_in_pkt;
  endtask

  // One clock: drive FIFO heads, check at the negedge, pop what the DUT read.
  task automatic cycle();
    logic p_aw, p_ar, p_wd;
    drive();
    @(negedge clk);
    if (prev_v && !prev_r) begin
      chk("hold_valid", tlp_valid, 1);
      chk("hold_data", tlp_data, prev_d);
      chk("hold_sop", tlp_sop, prev_s);
      chk("hold_eop", tlp_eop, prev_e);
    end
    if (tlp_valid && !tlp_ready) chk("stall_no_pop", {aw_hdr_rden, ar_hdr_rden, wd_rden}, 0);
    if (busy) chk("no_rd_in_pkt", ar_hdr_rden, 0);
    chk("single_pop", (int'(aw_hdr_rden) + int'(ar_hdr_rden) + int'(wd_rden)) > 1, 0);
    if (pend_pop) begin
      chk("pop_lat_valid", tlp_valid, 1);
      chk("pop_lat_data", tlp_data, pend_val);
    end
    if (tlp_valid && tlp_ready) accept();
    prev_v = tlp_valid; prev_r = tlp_ready; prev_d = tlp_data; prev_s = tlp_sop; prev_e = tlp_eop;
    p_aw = aw_hdr_rden; p_ar = ar_hdr_rden; p_wd = wd_rden;
    pend_pop = p_aw || p_ar || p_wd;
    pend_val = p_aw ? {128'b0, aw_hdr_rdata} : p_ar ? {128'b0, ar_hdr_rdata} : wd_rdata;
    @(posedge clk);
    #1;
    if (p_aw) void'(aw_q.pop_front());
    if (p_ar) void'(ar_q.pop_front());
    if (p_wd) void'(wd_q.pop_front());
    if (wd_hide > 0) wd_hide--;
  endtask

  task automatic drain(input string tag, input int budget);
    tlp_ready = 1'b1;
    for (int n = 0; n < budget && outstanding() != 0; n++) cycle();
    chk(tag, outstanding(), 0);
  endtask

  function automatic logic [7:0] order_bits();
    logic [7:0] ob;
    ob = '0;
    foreach (order_log[i]) ob = {ob[6:0], order_log[i]};
    return ob;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, tlp_valid, 0);
    chk({tag, "_data"}, tlp_data, 0);
    chk({tag, "_sopeop"}, {tlp_sop, tlp_eop}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rden"}, {aw_hdr_rden, ar_hdr_rden, wd_rden}, 0);
  endtask

  initial begin
    logic [7:0] exp_tie;
    // Reset state
    rst = 1'b1;
    drive();
    repeat (2) begin @(negedge clk); reset_checks("reset"); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Tie between three reads and three 1-beat writes
    order_log.delete();
    for (int i = 0; i < 3; i++) begin push_rd(1); push_wr(8); end
    drain("tie_drain", 200);
`ifdef TLP_TX_WR_PRIORITY_EN
    exp_tie = 8'b0011_1000;
`else
    exp_tie = 8'b0010_1010;
`endif
    chk("tie_order", order_bits(), exp_tie);
    chk("tie_count", order_log.size(), 6);

    // Single read
    order_log.delete();
    push_rd(1);
    drain("rd_drain", 50);
    chk("rd_len", last_pkt_len, 1);
    chk("rd_count", order_log.size(), 1);

    // Single write len=16
    order_log.delete();
    push_wr(16);
    drain("wr16_drain", 50);
    chk("wr16_len", last_pkt_len, 3);
    chk("wr16_order", order_bits(), 8'b1);

    // Backpressure on the second payload beat
    push_wr(24);
    for (int n = 0; n < 50 && !(acc_in_pkt == 2 && wr_left == 2); n++) cycle();
    chk("bp_reach", (acc_in_pkt == 2 && wr_left == 2), 1);
    tlp_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("bp_valid", tlp_valid, 1);
      chk("bp_sop", tlp_sop, 0);
    end
    drain("bp_drain", 50);
    chk("bp_len", last_pkt_len, 4);

    // Write-data FIFO dry for 3 cycles mid-packet with a read waiting
    order_log.delete();
    push_wr(32);
    for (int n = 0; n < 20 && !busy; n++) cycle();
    push_rd(1);
    for (int n = 0; n < 50 && !(acc_in_pkt == 2 && wr_left == 3); n++) cycle();
    chk("gap_reach", (acc_in_pkt == 2 && wr_left == 3), 1);
    wd_hide = 3;
    repeat (3) begin
      cycle();
      chk("gap_valid", tlp_valid, 0);
      chk("gap_busy", busy, 1);
    end
    cycle();
    chk("gap_resume", tlp_valid, 1);
    drain("gap_drain", 50);
    chk("gap_order", order_bits(), 8'b10);
    chk("gap_wr_len", order_log.size(), 2);

    // len=0 encodes 1024 DW
    push_wr(0);
    drain("len0_drain", 400);
    chk("len0_len", last_pkt_len, 129);

    // Randomized traffic with backpressure and data gaps
    for (int n = 0; n < 600; n++) begin
      tlp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) push_rd($urandom_range(1, 1023));
      if ($urandom_range(0, 9) == 0) push_wr($urandom_range(1, 64));
      if ($urandom_range(0, 15) == 0 && wd_hide == 0) wd_hide = $urandom_range(1, 3);
      cycle();
    end
    drain("rand_drain", 5000);

    // Asynchronous reset in the middle of a write
    push_wr(64);
    for (int n = 0; n < 50 && !(acc_in_pkt >= 3 && wr_left > 0); n++) cycle();
    chk("rst_reach", (acc_in_pkt >= 3 && wr_left > 0), 1);
    push_rd(1);
    drive();
    #2 rst = 1'b1;
    #1 reset_checks("midrst");
    aw_q.delete(); ar_q.delete(); wd_q.delete();
    exp_rd.delete(); exp_wr.delete(); exp_wd.delete();
    wr_left = 0; acc_in_pkt = 0; pend_pop = 1'b0; prev_v = 1'b0; wd_hide = 0;
    drive();
    @(negedge clk) reset_checks("midrst_hold");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    order_log.delete();
    push_rd(1);
    drain("post_rst_drain", 50);
    chk("post_rst_count", order_log.size(), 1);
    chk("post_rst_len", last_pkt_len, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlp_tx_scheduler.md
# tlp_tx_scheduler

Transmit-side scheduler of the transaction layer. It arbitrates between the AW (memory-write) header FIFO and the AR (memory-read) header FIFO, then sequences each write header together with its payload beats from the write-data FIFO. The result is a single 256-bit TLP stream toward the data link layer. Packets are never interleaved: once a write header is issued, all of its payload beats follow before another header is granted.

## Interface
- ADDR_WIDTH, PCIE_PKG::ADDR_WIDTH, carried for package consistency; not used in datapath
- clk  input  1  single clock for all logic
- rst  input  1  asynchronous, active-high reset
- aw_hdr_empty  input  1  AW header FIFO empty (FWFT)
- aw_hdr_rdata  input  128  AW header FIFO head
- aw_hdr_rden  output  1  pop AW header FIFO
- ar_hdr_empty  input  1  AR header FIFO empty (FWFT)
- ar_hdr_rdata  input  128  AR header FIFO head
- ar_hdr_rden  output  1  pop AR header FIFO
- wd_empty  input  1  write-data FIFO empty (FWFT)
- wd_rdata  input  256  write-data FIFO head, one 8-DW beat
- wd_rden  output  1  pop write-data FIFO
- tlp_valid  output  1  output beat valid
- tlp_ready  input  1  downstream accepts beat
- tlp_data  output  256  output beat
- tlp_sop  output  1  first beat of TLP
- tlp_eop  output  1  last beat of TLP
- busy  output  1  write packet in progress (state DATA)

## Operation
- All FIFOs are first-word-fall-through. Asserting rden for one cycle pops the head at that clock edge. rden is combinational, and is asserted only when the FIFO is non-empty and the output register is loading.
- Output register is "free" when `!tlp_valid || tlp_ready`. tlp_data, tlp_sop and tlp_eop load only when it is free; otherwise they hold stable while tlp_valid=1.
- State IDLE:
  - A write is eligible when `!aw_hdr_empty && !wd_empty`. A read is eligible when `!ar_hdr_empty`.
  - If the output register is free and at least one request is eligible, grant one request (see Arbitration).
  - On a read grant: pop AR; load `tlp_data={128'b0, ar_hdr_rdata}`, sop=1, eop=1; stay in IDLE.
  - On a write grant: pop AW; load `{128'b0, aw_hdr_rdata}`, sop=1, eop=0; load beat counter; go to DATA.
  - If the output register is free and nothing is eligible, tlp_valid goes to 0.
- State DATA:
  - If the output register is free and `!wd_empty`: pop write-data FIFO; load `wd_rdata`, sop=0, eop=(cnt==1); decrement cnt. When cnt reaches 0, return to IDLE.
  - If the output register is free and wd_empty: tlp_valid goes to 0 (bubble); stay in DATA.
- Beat count:
  - Length = header bits [9:0], in DWs; a value of 0 means 1024.
  - `beats = (len + 7) >> 3`, computed in 11-bit arithmetic. cnt is 8 bits wide, with a maximum of 128.
- Arbitration:
  - Round-robin using a 1-bit `last_grant` register, updated on every grant.
  - When both write and read are eligible, grant the opposite of `last_grant`. When only one is eligible, grant it.

## Timing
- Reset values: tlp_valid=0, tlp_data=0, tlp_sop=0, tlp_eop=0, busy=0, state=IDLE, cnt=0, last_grant=read (so a write wins the first tie).
- rden outputs are combinational with no reset value; they are 0 during reset.
- Latency: a FIFO pop at edge N makes the corresponding beat visible at N+1.
- With tlp_ready held high and sources non-empty there are no bubbles. A 1-DW read occupies one cycle; a write of L DW occupies `1 + beats` cycles.
- Back-to-back packets: a new grant may occur in the same cycle that the eop beat is accepted.
- If tlp_ready is low while tlp_valid=1, the output holds and no FIFO is popped.
- Reset mid-packet: all state clears immediately and the partial TLP is dropped. The upstream FIFOs must be reset together with this block.

## Configuration
- TLP_TX_WR_PRIORITY_EN defined: fixed priority is used; an eligible write always beats an eligible read, and `last_grant` is unused.
- TLP_TX_WR_PRIORITY_EN undefined: round-robin arbitration as described above.

## Test plan
- Single read: AR header with length=1 and tlp_ready=1. Required: one beat with sop=eop=1 and `tlp_data[127:0]`=header, one cycle after ar_hdr_rden.
- Single write of len=16: AW header plus 2 data beats. Required: 3 beats, sop on the first only, eop on the third, payload equal to the FIFO data in order.
- Backpressure: hold tlp_ready=0 for 5 cycles during a write's second beat. Required: data, sop and eop stay stable, no rden pulses, and the packet resumes intact.
- Tie: 3 reads and 3 writes (len=8) all pending. Required: order W,R,W,R,W,R. With TLP_TX_WR_PRIORITY_EN defined: W,W,W,R,R,R.
- Edge cases:
  - len=0 write: 128 data beats, eop on beat 128.
  - wd_empty for 3 cycles mid-packet: tlp_valid=0 for 3 cycles, no read is interleaved, and busy=1 throughout.
- Async reset asserted mid-write: outputs go to 0 immediately. After release, a new read is emitted with sop=1.
